// File: rtl/jk_bank_sequencer.sv
// Sequences one-cycle J/K drive pulses into a bank of JK flip-flops for clear/set/load/toggle/count
// commands, then checks the bank's Q one cycle after each pulse and latches any mismatch in a sticky Err.
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CmdValid,
    output logic             CmdReady,
    input  logic [2:0]       Cmd,
    input  logic [WIDTH-1:0] Data,
    input  logic [CNT_W-1:0] Steps,
    input  logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);
    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE} state_t;

    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_UP     = 3'd5;
    localparam logic [2:0] OP_DOWN   = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] steps_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] j_q, k_q;
    logic             done_q, err_q;

    logic [2:0]       pat_op;
    logic [WIDTH-1:0] pat_data;
    logic [WIDTH-1:0] chain_up, chain_dn;
    logic [WIDTH-1:0] j_d, k_d, exp_d;
    logic             is_count, starts_drive;

    // In IDLE the pattern comes from the incoming command; on a count re-drive it comes from the captured one.
    always_comb begin
        pat_op   = (state_q == IDLE) ? Cmd  : op_q;
        pat_data = (state_q == IDLE) ? Data : data_q;
        chain_up = '0;
        chain_dn = '0;
        chain_up[0] = 1'b1;
        chain_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            chain_up[i] = chain_up[i-1] & Q[i-1];
            chain_dn[i] = chain_dn[i-1] & ~Q[i-1];
        end
        j_d   = '0;
        k_d   = '0;
        exp_d = '0;
        case (pat_op)
            OP_CLEAR:  begin j_d = '0;       k_d = '1;        exp_d = '0;            end
            OP_SET:    begin j_d = '1;       k_d = '0;        exp_d = '1;            end
            OP_LOAD:   begin j_d = pat_data; k_d = ~pat_data; exp_d = pat_data;      end
            OP_TOGGLE: begin j_d = pat_data; k_d = pat_data;  exp_d = Q ^ pat_data;  end
            OP_UP:     begin j_d = chain_up; k_d = chain_up;  exp_d = Q + WIDTH'(1); end
            OP_DOWN:   begin j_d = chain_dn; k_d = chain_dn;  exp_d = Q - WIDTH'(1); end
            default:   begin j_d = '0;       k_d = '0;        exp_d = '0;            end
        endcase
        is_count     = (Cmd == OP_UP) || (Cmd == OP_DOWN);
        starts_drive = ((Cmd >= OP_CLEAR) && (Cmd <= OP_TOGGLE)) ||
                       (is_count && (Steps != '0));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            op_q    <= '0;
            data_q  <= '0;
            steps_q <= '0;
            exp_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            j_q    <= '0;
            k_q    <= '0;
            case (state_q)
                IDLE: begin
                    if (CmdValid) begin
                        op_q   <= Cmd;
                        data_q <= Data;
                        if (starts_drive) begin
                            state_q <= DRIVE;
                            j_q     <= j_d;
                            k_q     <= k_d;
                            exp_q   <= exp_d;
                            steps_q <= is_count ? Steps : CNT_W'(1);
                        end else begin
                            done_q <= 1'b1;
                            if (Cmd == OP_RSVD) err_q <= 1'b1;
                        end
                    end
                end
                DRIVE: state_q <= SETTLE;
                SETTLE: begin
                    if (Q != exp_q) err_q <= 1'b1;
                    if (steps_q > CNT_W'(1)) begin
                        steps_q <= steps_q - CNT_W'(1);
                        state_q <= DRIVE;
                        j_q     <= j_d;
                        k_q     <= k_d;
                        exp_q   <= exp_d;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign CmdReady = (state_q == IDLE) && !RST;
    assign Busy     = (state_q != IDLE);
    assign J        = j_q;
    assign K        = k_q;
    assign Done     = done_q;
    assign Err      = err_q;
endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Controller that sequences a bank of WIDTH edge-triggered JK flip-flops sharing CLK: per-bit J/K drive plus Q feedback.
- Accepts clear/set/load/toggle/count commands over a valid/ready handshake and issues one-cycle J/K drive pulses separated by hold cycles.
- Checks the bank's Q after every drive pulse and flags mismatches.
- Sits between a host FSM/testbench and the flip-flop bank.

Parameters:
- WIDTH, 4, number of JK flip-flops in the bank.
- CNT_W, 8, width of the count-step field.

Ports:
- CLK  in  1  clock; everything is rising-edge, including the bank.
- RST  in  1  asynchronous, active-high reset.
- CmdValid  in  1  command present.
- CmdReady  out  1  block can accept a command.
- Cmd  in  3  opcode: 0 NOP, 1 CLEAR, 2 SET, 3 LOAD, 4 TOGGLE, 5 UP, 6 DOWN, 7 reserved.
- Data  in  WIDTH  LOAD value or TOGGLE mask.
- Steps  in  CNT_W  count steps for UP/DOWN.
- Q  in  WIDTH  bank outputs.
- J  out  WIDTH  bank J inputs (registered).
- K  out  WIDTH  bank K inputs (registered).
- Busy  out  1  command in progress.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  sticky error flag.

Behaviour:
- Reset (async, immediate, no clock needed):
  - J=0, K=0, Busy=0, Done=0, Err=0, state IDLE.
  - The bank is not reset; J=K=0 makes it hold.
- Handshake:
  - CmdReady = (state==IDLE) and not RST.
  - A command is accepted at a rising edge with CmdValid & CmdReady. Cmd/Data/Steps are captured then.
  - CmdValid is ignored while Busy.
- States and transitions:
  - IDLE -> DRIVE on accept of opcodes 1-4, or 5/6 with Steps!=0.
  - DRIVE: exactly one cycle; J/K hold the pulse pattern.
  - SETTLE: exactly one cycle; J=K=0.
- Busy: 1 in DRIVE and SETTLE, 0 in IDLE.
- J/K pattern, registered on the edge that enters DRIVE:
  - CLEAR: J=0, K=all 1.
  - SET: J=all 1, K=0.
  - LOAD: J=Data, K=~Data.
  - TOGGLE: J=K=Data.
  - UP: J[i]=K[i]=&Q[i-1:0], with bit0=1.
  - DOWN: J[i]=K[i]=&~Q[i-1:0], with bit0=1.
  - J=K=0 at all other times. No J/K bit is ever nonzero for more than one consecutive cycle.
- Expected value, captured alongside the pattern:
  - CLEAR 0; SET all 1; LOAD Data; TOGGLE Q^Data.
  - UP Q+1 mod 2^WIDTH; DOWN Q-1 mod 2^WIDTH.
  - Wrap-around is natural: 1111 -> 0000 on UP.
- Check on the edge leaving SETTLE:
  - If Q != expected, set Err.
  - If step counter > 1, decrement it and go to DRIVE, computing the new pattern from the current, updated Q.
  - Otherwise go to IDLE and pulse Done.
- Latency (accept at edge t):
  - Single-pulse ops: Done high for the cycle after edge t+2.
  - UP/DOWN with N steps: Done after edge t+2N.
  - Back-to-back: next accept possible at edge t+3, or t+2N+1 for counts.
- Zero-drive ops: NOP, UP/DOWN with Steps=0, and opcode 7 go straight to IDLE. Done pulses the cycle after accept, with no J/K activity.
- Opcode 7 also sets Err.
- Err: sticky; cleared only by RST; never blocks operation.
- Done: asserted only in IDLE, one cycle, never coincident with Busy.
- Reset mid-operation: drive is aborted within the same cycle. The bank keeps whatever state the last completed edge produced. No Done is issued.

Test Plan:
- Reset, then CLEAR accepted at edge t -> J=0000, K=1111 for exactly one cycle; Q=0000 after edge t+1; Done after edge t+2; Err=0.
- LOAD Data=1010, then TOGGLE Data=0110 -> Q=1010, then Q=1100; second accept at the edge immediately after the first Done cycle; Err=0.
- LOAD 1110, then UP Steps=3 -> Q sequence 1111, 0000, 0001; Busy high 6 cycles; single Done pulse; Err=0.
- From Q=0000, DOWN Steps=1 -> Q=1111. UP Steps=0 -> Done next cycle, J=K=0 throughout.
- Cmd=7 -> Err=1, no J/K activity, Done next cycle. Subsequent CLEAR completes normally with Err still 1. Bench forcing Q stuck at 0101 during LOAD 0011 also sets Err.
- RST asserted asynchronously mid-edge-cycle during DRIVE of UP Steps=5 -> J=K=0, Busy=0, CmdReady=0 immediately. After release: CmdReady=1, no Done, Q holds.
